pattern_sequencer: RTL

Pattern sequencer for one synthesizer channel, directly upstream of the channel controller. It is enabled for one cycle whenever the controller needs a new note. It then walks a pattern ROM of 16-bit entries, resolves jump and end markers, and returns the next note or rest and its duration with a one-cycle valid pulse. The returned note feeds the pitch lookup, and the returned duration loads the duration counter.

---
 rtl/synth_pkg.sv | 28 ++
 rtl/pattern_sequencer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/synth_pkg.sv
// Shared synthesizer-channel definitions: pattern entry layout,
// opcodes, field widths and the pattern sequencer state encoding.
package synth_pkg;

  localparam int NOTE_WIDTH     = 6;
  localparam int DURATION_WIDTH = 8;
  localparam int ENTRY_WIDTH    = 16;

  localparam int OP_MSB   = 15;
  localparam int OP_LSB   = 14;
  localparam int NOTE_MSB = 13;
  localparam int NOTE_LSB = 8;
  localparam int DUR_MSB  = 7;
  localparam int DUR_LSB  = 0;

  localparam logic [1:0] OP_NOTE = 2'b00;
  localparam logic [1:0] OP_REST = 2'b01;
  localparam logic [1:0] OP_JUMP = 2'b10;
  localparam logic [1:0] OP_END  = 2'b11;

  typedef enum logic [1:0] {
    PS_IDLE,
    PS_FETCH,
    PS_DECODE,
    PS_HALTED
  } ps_state_e;

endpackage

// File: rtl/pattern_sequencer.sv
// Pattern sequencer: on each i_enable walks the pattern ROM (resolving
// JUMP/END) and returns the next note or rest with a one-cycle o_valid.
// Ports: i_clk, i_rst (sync, active-high), i_enable, o_rom_addr,
//   i_rom_data, o_valid, o_note, o_rest, o_duration, o_done.
// Option: PATTERN_SEQ_LOOP_EN enables JUMP decoding and the jump guard;
//   without it opcode 10 decodes as END.
module pattern_sequencer
  import synth_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int START_ADDR = 0,
  parameter int MAX_JUMPS  = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_enable,
  output logic [ADDR_WIDTH-1:0]     o_rom_addr,
  input  logic [ENTRY_WIDTH-1:0]    i_rom_data,
  output logic                      o_valid,
  output logic [NOTE_WIDTH-1:0]     o_note,
  output logic                      o_rest,
  output logic [DURATION_WIDTH-1:0] o_duration,
  output logic                      o_done
);

  if (MAX_JUMPS < 1 || ADDR_WIDTH < 1 ||
      ADDR_WIDTH > NOTE_MSB + 1) begin : g_param_chk
    $error("pattern_sequencer: bad parameters");
  end

  localparam logic [ADDR_WIDTH-1:0] PC_RST =
    ADDR_WIDTH'(START_ADDR);

  ps_state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]     pc_q, pc_d;
  logic                      valid_q, valid_d;
  logic [NOTE_WIDTH-1:0]     note_q, note_d;
  logic                      rest_q, rest_d;
  logic [DURATION_WIDTH-1:0] dur_q, dur_d;
  logic                      done_q, done_d;
  logic                      halt;

  logic [1:0] op;
  logic       is_note;
  logic       is_rest;

  assign op      = i_rom_data[OP_MSB:OP_LSB];
  assign is_note = (op == OP_NOTE);
  assign is_rest = (op == OP_REST);

`ifdef PATTERN_SEQ_LOOP_EN
  localparam int JCW = $clog2(MAX_JUMPS + 1);
  localparam logic [JCW-1:0] JMAX = JCW'(MAX_JUMPS);

  logic [JCW-1:0] jcnt_q, jcnt_d;
  logic           is_jump;

  assign is_jump = (op == OP_JUMP);
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = 1'b0;
    note_d  = note_q;
    rest_d  = rest_q;
    dur_d   = dur_q;
    done_d  = done_q;
    halt    = 1'b0;
`ifdef PATTERN_SEQ_LOOP_EN
    jcnt_d  = jcnt_q;
`endif
    unique case (state_q)
      PS_IDLE: begin
        if (i_enable) state_d = PS_FETCH;
      end
      PS_FETCH: begin
        state_d = PS_DECODE;
      end
      PS_DECODE: begin
        unique case (1'b1)
          is_note: begin
            note_d  = i_rom_data[NOTE_MSB:NOTE_LSB];
            dur_d   = i_rom_data[DUR_MSB:DUR_LSB];
            rest_d  = 1'b0;
            pc_d    = pc_q + 1'b1;
            valid_d = 1'b1;
            state_d = PS_IDLE;
`ifdef PATTERN_SEQ_LOOP_EN
            jcnt_d  = '0;
`endif
          end
          is_rest: begin
            dur_d   = i_rom_data[DUR_MSB:DUR_LSB];
            rest_d  = 1'b1;
            pc_d    = pc_q + 1'b1;
            valid_d = 1'b1;
            state_d = PS_IDLE;
`ifdef PATTERN_SEQ_LOOP_EN
            jcnt_d  = '0;
`endif
          end
`ifdef PATTERN_SEQ_LOOP_EN
          is_jump: begin
            if (jcnt_q < JMAX) begin
              pc_d    = i_rom_data[ADDR_WIDTH-1:0];
              jcnt_d  = jcnt_q + 1'b1;
              state_d = PS_FETCH;
            end else begin
              // too many chained jumps: stop as if END
              halt = 1'b1;
            end
          end
`endif
          default: halt = 1'b1;
        endcase
        if (halt) begin
          done_d  = 1'b1;
          rest_d  = 1'b1;
          dur_d   = '0;
          valid_d = 1'b1;
          state_d = PS_HALTED;
        end
      end
      PS_HALTED: begin
        // keep returning a zero-length rest; never pulse twice in a row
        valid_d = i_enable & ~valid_q;
      end
      default: state_d = PS_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= PS_IDLE;
      pc_q    <= PC_RST;
      valid_q <= 1'b0;
      note_q  <= '0;
      rest_q  <= 1'b1;
      dur_q   <= '0;
      done_q  <= 1'b0;
`ifdef PATTERN_SEQ_LOOP_EN
      jcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      note_q  <= note_d;
      rest_q  <= rest_d;
      dur_q   <= dur_d;
      done_q  <= done_d;
`ifdef PATTERN_SEQ_LOOP_EN
      jcnt_q  <= jcnt_d;
`endif
    end
  end

  assign o_rom_addr = pc_q;
  assign o_valid    = valid_q;
  assign o_note     = note_q;
  assign o_rest     = rest_q;
  assign o_duration = dur_q;
  assign o_done     = done_q;

endmodule
